// File: rtl/pattern_count_engine.sv
// Read-only memory master that scans NUM_BYTES words and counts PAT_W-bit pattern
// hits within words, words with any hit, and across the MSB-first concatenated bitstream.
module pattern_count_engine #(
  parameter int DATA_W    = 8,
  parameter int PAT_W     = 5,
  parameter int NUM_BYTES = 32,
  parameter int ADDR_W    = 8,
  parameter int CNT_W     = $clog2(NUM_BYTES * DATA_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [PAT_W-1:0]  pat,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  cnt_within,
  output logic [CNT_W-1:0]  cnt_bytes,
  output logic [CNT_W-1:0]  cnt_cross
);

  localparam int CW    = (PAT_W > 1) ? PAT_W - 1 : 1;
  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  if (PAT_W < 1 || PAT_W > DATA_W) begin : g_bad_pat_w
    $error("pattern_count_engine: PAT_W must lie in 1..DATA_W");
  end
  if (NUM_BYTES < 1) begin : g_bad_num_bytes
    $error("pattern_count_engine: NUM_BYTES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [PAT_W-1:0]    pat_q, pat_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                rd_en_q, rd_en_d;
  logic                valid_q, valid_d;
  logic                first_q, first_d;
  logic [CW-1:0]       carry_q, carry_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    within_q, within_d;
  logic [CNT_W-1:0]    bytes_q, bytes_d;
  logic [CNT_W-1:0]    cross_q, cross_d;
  logic [CNT_W-1:0]    hits;
  logic [CNT_W-1:0]    span;
  logic [CW+DATA_W-1:0] cat;

  // In-word windows plus the windows that straddle the previous word's tail.
  always_comb begin
    hits = '0;
    span = '0;
    cat  = {carry_q, mem_rdata};
    for (int k = 0; k <= DATA_W - PAT_W; k++) begin
      if (mem_rdata[k +: PAT_W] == pat_q) hits = hits + CNT_W'(1);
    end
    for (int k = DATA_W - PAT_W + 1; k < DATA_W; k++) begin
      if (cat[k +: PAT_W] == pat_q) span = span + CNT_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    base_d   = base_q;
    addr_d   = addr_q;
    idx_d    = idx_q;
    rd_en_d  = rd_en_q;
    valid_d  = rd_en_q;
    first_d  = first_q;
    carry_d  = carry_q;
    busy_d   = busy_q;
    done_d   = done_q;
    within_d = within_q;
    bytes_d  = bytes_q;
    cross_d  = cross_q;

    if (valid_q) begin
      within_d = within_q + hits;
      bytes_d  = bytes_q + ((hits != '0) ? CNT_W'(1) : CNT_W'(0));
      cross_d  = cross_q + hits + (first_q ? CNT_W'(0) : span);
      carry_d  = mem_rdata[CW-1:0];
      first_d  = 1'b0;
    end

    case (state_q)
      IDLE, DONE: begin
        if (req) begin
          state_d  = RUN;
          pat_d    = pat;
          base_d   = base_addr;
          idx_d    = '0;
          carry_d  = '0;
          first_d  = 1'b1;
          within_d = '0;
          bytes_d  = '0;
          cross_d  = '0;
          rd_en_d  = 1'b0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
        end
      end
      RUN: begin
        rd_en_d = 1'b1;
        addr_d  = base_q + ADDR_W'(idx_q);
        if (idx_q == LAST_IDX) state_d = DRAIN;
        else                   idx_d   = idx_q + IDX_W'(1);
      end
      DRAIN: begin
        rd_en_d = 1'b0;
        // The last read has left the bus; its data is being absorbed this cycle.
        if (!rd_en_q) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pat_q    <= '0;
      base_q   <= '0;
      addr_q   <= '0;
      idx_q    <= '0;
      rd_en_q  <= 1'b0;
      valid_q  <= 1'b0;
      first_q  <= 1'b0;
      carry_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      within_q <= '0;
      bytes_q  <= '0;
      cross_q  <= '0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      base_q   <= base_d;
      addr_q   <= addr_d;
      idx_q    <= idx_d;
      rd_en_q  <= rd_en_d;
      valid_q  <= valid_d;
      first_q  <= first_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      within_q <= within_d;
      bytes_q  <= bytes_d;
      cross_q  <= cross_d;
    end
  end

  assign mem_rd_en  = rd_en_q;
  assign mem_addr   = addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cnt_within = within_q;
  assign cnt_bytes  = bytes_q;
  assign cnt_cross  = cross_q;

endmodule

// File: tb/tb_pattern_count_engine.sv
// Bench for pattern_count_engine: directed vector table, random jobs against a
// bitstream reference model, and multi-cycle req/reset corner sequences.
module tb_pattern_count_engine;

  localparam int N = 32;

  logic       clk;
  logic       reset;
  logic       req;
  logic [7:0] base_addr;
  logic [4:0] pat;
  logic       mem_rd_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       done;
  logic [8:0] cnt_within;
  logic [8:0] cnt_bytes;
  logic [8:0] cnt_cross;

  int checks;
  int errors;

  logic [7:0] mem [256];
  logic [7:0] job_data [N];
  logic [7:0] addr_log [$];

  pattern_count_engine dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .base_addr  (base_addr),
    .pat        (pat),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .cnt_within (cnt_within),
    .cnt_bytes  (cnt_bytes),
    .cnt_cross  (cnt_cross)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory; garbage on the bus whenever no read was issued.
  always @(posedge clk) begin
    mem_rdata <= mem_rd_en ? mem[mem_addr] : 8'($urandom);
    if (mem_rd_en) addr_log.push_back(mem_addr);
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Counts taken straight from the definition: slide windows over each byte and
  // over the flattened MSB-first bit list.
  function automatic void ref_model(input logic [4:0] p, output int w, output int b, output int c);
    bit bits[$];
    int len;
    logic [4:0] v;
    w = 0; b = 0; c = 0;
    for (int i = 0; i < N; i++) begin
      int h = 0;
      for (int k = 0; k <= 3; k++)
        if (((job_data[i] >> k) & 8'h1f) == {3'b000, p}) h++;
      w += h;
      if (h > 0) b++;
      for (int j = 7; j >= 0; j--) bits.push_back(job_data[i][j]);
    end
    len = bits.size();
    for (int s = 0; s + 5 <= len; s++) begin
      v = '0;
      for (int t = 0; t < 5; t++) v = {v[3:0], bits[s + t]};
      if (v == p) c++;
    end
  endfunction

  task automatic load_job(input logic [7:0] b);
    logic [7:0] a;
    for (int i = 0; i < N; i++) begin
      a = b + 8'(i);
      mem[a] = job_data[i];
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] b, input logic [4:0] p);
    @(negedge clk);
    base_addr = b;
    pat       = p;
    req       = 1'b1;
    addr_log.delete();
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (!done && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (!done) check_output("done_timeout", 0, 1);
  endtask

  task automatic check_counts(input string tag, input logic [4:0] p);
    int w, b, c;
    ref_model(p, w, b, c);
    check_output({tag, "_within"}, int'(cnt_within), w);
    check_output({tag, "_bytes"},  int'(cnt_bytes),  b);
    check_output({tag, "_cross"},  int'(cnt_cross),  c);
  endtask

  task automatic check_addrs(input string tag, input logic [7:0] b);
    int bad;
    logic [7:0] e;
    bad = (addr_log.size() == N) ? 0 : 1;
    for (int i = 0; i < addr_log.size() && i < N; i++) begin
      e = b + 8'(i);
      if (addr_log[i] != e) bad++;
    end
    check_output({tag, "_addr_seq_bad"}, bad, 0);
  endtask

  typedef struct {
    logic [4:0] pat;
    logic [7:0] w0;
    logic [7:0] w1;
    logic [7:0] fill;
    int exp_w;
    int exp_b;
    int exp_c;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int edges;
    logic [4:0] p, p2;
    logic [7:0] base;

    checks = 0;
    errors = 0;
    req = 1'b0; base_addr = '0; pat = '0; reset = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    vecs[0] = '{5'b00000, 8'h00, 8'h00, 8'h00, 128, 32, 252};
    vecs[1] = '{5'b10101, 8'h55, 8'h55, 8'h55,  64, 32, 126};
    vecs[2] = '{5'b11111, 8'h07, 8'hC0, 8'h00,   0,  0,   1};
    vecs[3] = '{5'b11111, 8'hFF, 8'hFF, 8'hFF, 128, 32, 252};
    vecs[4] = '{5'b00000, 8'hFF, 8'hFF, 8'hFF,   0,  0,   0};
    vecs[5] = '{5'b00001, 8'h0F, 8'h0F, 8'h0F,  32, 32,  32};

    repeat (3) @(posedge clk);
    #1;
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_done", int'(done), 0);
    check_output("rst_rd_en", int'(mem_rd_en), 0);
    check_output("rst_counts", int'(cnt_within) + int'(cnt_bytes) + int'(cnt_cross), 0);
    @(negedge clk);
    reset = 1'b1;

    // Directed table: fixed word 0/1, rest filled.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < N; i++) job_data[i] = vecs[v].fill;
      job_data[0] = vecs[v].w0;
      job_data[1] = vecs[v].w1;
      load_job(8'h10);
      apply_stimulus(8'h10, vecs[v].pat);
      check_output("accept_busy", int'(busy), 1);
      check_output("accept_done", int'(done), 0);
      wait_done(edges);
      check_output("latency", edges, N + 2);
      check_output("vec_within", int'(cnt_within), vecs[v].exp_w);
      check_output("vec_bytes",  int'(cnt_bytes),  vecs[v].exp_b);
      check_output("vec_cross",  int'(cnt_cross),  vecs[v].exp_c);
      check_output("done_busy", int'(busy), 0);
    end

    // Random jobs with a wrapping base address.
    for (int j = 0; j < 50; j++) begin
      for (int i = 0; i < N; i++)
        job_data[i] = (j % 2 == 0) ? 8'($urandom) : 8'($urandom_range(0, 3) * 8'h55);
      p = 5'($urandom);
      load_job(8'hF0);
      apply_stimulus(8'hF0, p);
      wait_done(edges);
      check_counts("rand", p);
      check_addrs("rand", 8'hF0);
    end

    // req during a running job must be ignored.
    for (int i = 0; i < N; i++) job_data[i] = 8'($urandom_range(0, 3) * 8'h55);
    p = 5'b10101;
    load_job(8'h40);
    apply_stimulus(8'h40, p);
    repeat (9) @(posedge clk);
    @(negedge clk);
    req = 1'b1; pat = ~p; base_addr = 8'h00;
    @(posedge clk);
    #1;
    req = 1'b0;
    check_output("midreq_busy", int'(busy), 1);
    wait_done(edges);
    check_counts("midreq", p);
    check_addrs("midreq", 8'h40);
    repeat (5) @(posedge clk);
    #1;
    check_counts("hold", p);

    // Restart after done: done drops on the accepting edge.
    p2 = 5'b01010;
    apply_stimulus(8'h40, p2);
    check_output("restart_done", int'(done), 0);
    check_output("restart_busy", int'(busy), 1);
    wait_done(edges);
    check_counts("restart", p2);

    // Asynchronous reset mid-job, then a clean job.
    for (int i = 0; i < N; i++) job_data[i] = 8'($urandom);
    load_job(8'h80);
    apply_stimulus(8'h80, 5'b00000);
    repeat (14) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_output("arst_busy", int'(busy), 0);
    check_output("arst_done", int'(done), 0);
    check_output("arst_rd_en", int'(mem_rd_en), 0);
    check_output("arst_addr", int'(mem_addr), 0);
    check_output("arst_counts", int'(cnt_within) + int'(cnt_bytes) + int'(cnt_cross), 0);
    @(negedge clk);
    reset = 1'b1;
    p = 5'b00110;
    apply_stimulus(8'h80, p);
    wait_done(edges);
    check_output("post_rst_latency", edges, N + 2);
    check_counts("post_rst", p);
    check_addrs("post_rst", 8'h80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
